rename_freelist: RTL and testbench
==================================

Name: rename_freelist

Overview:
- Register-rename front end that drives a reorder buffer's allocate port and consumes its commit port.
- Holds the speculative RAT (arch reg -> phys reg), the retirement RAT, and a circular free list of physical registers.
- On each accepted rename it pops a free physical register, updates the RAT, and issues an allocate to the ROB with new and old mappings.
- On each commit it returns the old physical register to the free list and updates the retirement RAT.

Parameters:
- ARCH, 32, number of architectural registers
- PHYS, 64, number of physical registers (PHYS > ARCH)
- AW, $clog2(ARCH), arch register index width
- PW, $clog2(PHYS), phys register index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ren_valid  in  1  rename request
- ren_ready  out  1  rename accepted this cycle when high with ren_valid
- ren_ard  in  AW  destination arch reg
- ren_rs1  in  AW  source 1 arch reg
- ren_rs2  in  AW  source 2 arch reg
- ren_ps1  out  PW  phys mapping of ren_rs1
- ren_ps2  out  PW  phys mapping of ren_rs2
- rob_alloc_en  out  1  ROB allocate strobe
- rob_alloc_ok  in  1  ROB has space
- rob_ard  out  AW  = ren_ard
- rob_prd_new  out  PW  popped free register
- rob_prd_old  out  PW  previous mapping of ren_ard
- commit_valid  in  1  ROB head ready to retire
- commit_ard  in  AW  retiring arch reg
- commit_prd_new  in  PW  retiring new mapping
- commit_prd_old  in  PW  register to free
- commit_pop  out  1  retire acknowledge
- free_count  out  PW+1  free list occupancy
- rrat_rd_idx  in  AW  debug read index for the retirement RAT
- rrat_rd_data  out  PW  retirement RAT entry at rrat_rd_idx, combinational

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset state:
  - RAT[i] = i and RRAT[i] = i for all i < ARCH.
  - Free list holds ARCH..PHYS-1 in ascending order: head=0, tail=PHYS-ARCH, free_count=PHYS-ARCH.
  - All state is restored in one cycle, including when rst is asserted mid-stream.
- Outputs during rst: ren_ready=0, rob_alloc_en=0, commit_pop=0.
- ren_ready = !rst && free_count!=0 && rob_alloc_ok.
  - The value is computed from registered count only; no bypass of a same-cycle commit push.
- Rename is combinational and zero-latency:
  - rob_alloc_en = ren_valid && ren_ready.
  - rob_prd_new = fl[head].
  - rob_prd_old = RAT[ren_ard].
  - ren_ps1 = RAT[ren_rs1] and ren_ps2 = RAT[ren_rs2], using the pre-update RAT, so rs==ard in the same cycle returns the old mapping.
- On an accepted rename, at the clock edge:
  - RAT[ren_ard] <= fl[head].
  - head <= head+1, wrapping at PHYS.
  - count decrements.
- Commit:
  - commit_pop = commit_valid && !rst, so commit is always accepted.
  - On pop: fl[tail] <= commit_prd_old, tail <= tail+1 (wrap at PHYS), count increments, RRAT[commit_ard] <= commit_prd_new.
- Rename and commit in the same cycle: head and tail both advance and free_count is unchanged.
- Free list depth is PHYS, so overflow cannot occur with a correct ROB. free_count > PHYS-ARCH is a protocol error and is covered by an assertion in simulation.
- Wrap-around: head and tail wrap independently. fl is a storage array only; the full/empty decision uses count, not pointer equality.
- ren_valid with ren_ready=0 causes no state change; the requester holds the request.

Optional Feature:
- Macro: RENAME_ZERO_REG_EN.
- Defined:
  - Arch reg 0 is hardwired to phys reg 0.
  - A rename with ren_ard=0 still allocates in the ROB but pops nothing: rob_prd_new=0, rob_prd_old=0, RAT unchanged, and ren_ready ignores free_count.
  - Commit with commit_prd_old=0 pops the ROB but pushes nothing onto the free list.
  - RRAT[0] stays 0.
- Undefined: reg 0 is renamed like any other register.

Test Plan:
- Reset, then one rename with ard=5, rs1=5 -> ps1=5, prd_old=5, prd_new=32, rob_alloc_en=1; next cycle RAT[5]=32, free_count=31.
- 32 back-to-back renames, no commits -> free_count=0, ren_ready=0; the 33rd request stalls and RAT is unchanged.
- From the empty state, commit prd_old=5 with ard=5, prd_new=32 -> commit_pop=1, free_count=1, RRAT[5]=32; a subsequent rename gets prd_new=5.
- Rename and commit in the same cycle with free_count=10 -> free_count stays 10, head and tail both advance.
- rob_alloc_ok=0 with ren_valid=1 and free_count>0 -> rob_alloc_en=0, no pop; 100 rename/commit pairs force head and tail wrap past 63 with correct FIFO order.
- Assert rst after 7 renames -> next cycle free_count=32, RAT identity, next rename gets prd_new=32. With RENAME_ZERO_REG_EN, rename ard=0 -> prd_new=0 and free_count unchanged.

Source files
------------

// File: rtl/rename_freelist.sv
// rename_freelist: register-rename front end with speculative RAT, retirement RAT and circular free list.
// Optional feature macro RENAME_ZERO_REG_EN: arch reg 0 is hardwired to phys reg 0.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   ren_valid/ren_ready               rename handshake
//   ren_ard, ren_rs1, ren_rs2         destination and source arch regs
//   ren_ps1, ren_ps2                  source phys mappings (pre-update RAT)
//   rob_alloc_en, rob_alloc_ok        ROB allocate strobe and ROB space
//   rob_ard, rob_prd_new, rob_prd_old ROB allocate payload
//   commit_valid, commit_ard,
//   commit_prd_new, commit_prd_old    ROB retire payload
//   commit_pop                        retire acknowledge
//   free_count                        free list occupancy
//   rrat_rd_idx, rrat_rd_data         retirement RAT debug read
module rename_freelist #(
   parameter int ARCH = 32,
   parameter int PHYS = 64,
   parameter int AW   = $clog2(ARCH),
   parameter int PW   = $clog2(PHYS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ren_valid,
   output logic          ren_ready,
   input  logic [AW-1:0] ren_ard,
   input  logic [AW-1:0] ren_rs1,
   input  logic [AW-1:0] ren_rs2,
   output logic [PW-1:0] ren_ps1,
   output logic [PW-1:0] ren_ps2,
   output logic          rob_alloc_en,
   input  logic          rob_alloc_ok,
   output logic [AW-1:0] rob_ard,
   output logic [PW-1:0] rob_prd_new,
   output logic [PW-1:0] rob_prd_old,
   input  logic          commit_valid,
   input  logic [AW-1:0] commit_ard,
   input  logic [PW-1:0] commit_prd_new,
   input  logic [PW-1:0] commit_prd_old,
   output logic          commit_pop,
   output logic [PW:0]   free_count,
   input  logic [AW-1:0] rrat_rd_idx,
   output logic [PW-1:0] rrat_rd_data
);
   logic [PW-1:0] rat  [ARCH];
   logic [PW-1:0] rrat [ARCH];
   logic [PW-1:0] fl   [PHYS];
   logic [PW-1:0] head, tail;
   logic [PW:0]   count;
   logic          zero_dst, pop, push, rrat_we;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(PHYS - 1)) ? '0 : p + 1'b1;
   endfunction

`ifdef RENAME_ZERO_REG_EN
   // reg 0 never owns a free-list entry, so it neither pops nor pushes
   assign zero_dst = (ren_ard == '0);
   assign push     = commit_pop && (commit_prd_old != '0);
   assign rrat_we  = commit_pop && (commit_ard != '0);
`else
   assign zero_dst = 1'b0;
   assign push     = commit_pop;
   assign rrat_we  = commit_pop;
`endif

   // readiness uses the registered count only; a same-cycle commit is not bypassed
   assign ren_ready    = !rst && rob_alloc_ok && (count != '0 || zero_dst);
   assign rob_alloc_en = ren_valid && ren_ready;
   assign pop          = rob_alloc_en && !zero_dst;
   assign rob_ard      = ren_ard;
   assign rob_prd_new  = zero_dst ? '0 : fl[head];
   assign rob_prd_old  = rat[ren_ard];
   assign ren_ps1      = rat[ren_rs1];
   assign ren_ps2      = rat[ren_rs2];
   assign commit_pop   = commit_valid && !rst;
   assign free_count   = count;
   assign rrat_rd_data = rrat[rrat_rd_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ARCH; i++) begin
            rat[i]  <= PW'(i);
            rrat[i] <= PW'(i);
         end
         for (int i = 0; i < PHYS; i++)
            fl[i] <= PW'(i + ARCH);
         head  <= '0;
         tail  <= PW'(PHYS - ARCH);
         count <= (PW+1)'(PHYS - ARCH);
      end else begin
         if (pop) begin
            rat[ren_ard] <= fl[head];
            head         <= inc(head);
         end
         if (push) begin
            fl[tail] <= commit_prd_old;
            tail     <= inc(tail);
         end
         if (rrat_we)
            rrat[commit_ard] <= commit_prd_new;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   // more free registers than PHYS-ARCH means the ROB returned a register twice
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) count <= (PW+1)'(PHYS - ARCH));
endmodule

// File: tb/tb_rename_freelist.sv
// tb_rename_freelist: directed bench with a queue-based rename/ROB model checked every cycle.
module tb_rename_freelist;
   localparam int ARCH = 32;
   localparam int PHYS = 64;
   localparam int AW   = 5;
   localparam int PW   = 6;
`ifdef RENAME_ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          ren_valid, ren_ready;
   logic [AW-1:0] ren_ard, ren_rs1, ren_rs2;
   logic [PW-1:0] ren_ps1, ren_ps2;
   logic          rob_alloc_en, rob_alloc_ok;
   logic [AW-1:0] rob_ard;
   logic [PW-1:0] rob_prd_new, rob_prd_old;
   logic          commit_valid;
   logic [AW-1:0] commit_ard;
   logic [PW-1:0] commit_prd_new, commit_prd_old;
   logic          commit_pop;
   logic [PW:0]   free_count;
   logic [AW-1:0] rrat_rd_idx;
   logic [PW-1:0] rrat_rd_data;

   rename_freelist dut (
      .clk(clk), .rst(rst),
      .ren_valid(ren_valid), .ren_ready(ren_ready),
      .ren_ard(ren_ard), .ren_rs1(ren_rs1), .ren_rs2(ren_rs2),
      .ren_ps1(ren_ps1), .ren_ps2(ren_ps2),
      .rob_alloc_en(rob_alloc_en), .rob_alloc_ok(rob_alloc_ok),
      .rob_ard(rob_ard), .rob_prd_new(rob_prd_new), .rob_prd_old(rob_prd_old),
      .commit_valid(commit_valid), .commit_ard(commit_ard),
      .commit_prd_new(commit_prd_new), .commit_prd_old(commit_prd_old),
      .commit_pop(commit_pop), .free_count(free_count),
      .rrat_rd_idx(rrat_rd_idx), .rrat_rd_data(rrat_rd_data)
   );

   always #5 clk = ~clk;

   typedef struct {int ard; int pn; int po;} rob_t;
   int   m_rat [ARCH];
   int   m_rrat[ARCH];
   int   m_free[$];
   rob_t m_rob [$];
   bit   started = 1'b0;
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic bit exp_ready();
      return !rst && rob_alloc_ok && (m_free.size() != 0 || (ZR && ren_ard == 0));
   endfunction

   task automatic model_step();
      int n;
      if (rst) begin
         for (int i = 0; i < ARCH; i++) begin
            m_rat[i]  = i;
            m_rrat[i] = i;
         end
         m_free.delete();
         for (int i = ARCH; i < PHYS; i++) m_free.push_back(i);
         m_rob.delete();
         started = 1'b1;
         return;
      end
      if (ren_valid && exp_ready()) begin
         if (ZR && ren_ard == 0) m_rob.push_back('{0, 0, 0});
         else begin
            n = m_free.pop_front();
            m_rob.push_back('{int'(ren_ard), n, m_rat[ren_ard]});
            m_rat[ren_ard] = n;
         end
      end
      if (commit_valid) begin
         if (!(ZR && commit_prd_old == 0)) m_free.push_back(int'(commit_prd_old));
         if (!(ZR && commit_ard == 0)) m_rrat[commit_ard] = int'(commit_prd_new);
         if (m_rob.size() > 0) void'(m_rob.pop_front());
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (started) begin
         chk("ren_ready", int'(ren_ready), int'(exp_ready()));
         chk("rob_alloc_en", int'(rob_alloc_en), int'(ren_valid && exp_ready()));
         chk("commit_pop", int'(commit_pop), int'(commit_valid && !rst));
         chk("free_count", int'(free_count), m_free.size());
         chk("ren_ps1", int'(ren_ps1), m_rat[ren_rs1]);
         chk("ren_ps2", int'(ren_ps2), m_rat[ren_rs2]);
         chk("rob_prd_old", int'(rob_prd_old), m_rat[ren_ard]);
         chk("rob_ard", int'(rob_ard), int'(ren_ard));
         if (ZR && ren_ard == 0) chk("rob_prd_new_zero", int'(rob_prd_new), 0);
         else if (m_free.size() != 0) chk("rob_prd_new", int'(rob_prd_new), m_free[0]);
         chk("rrat_rd_data", int'(rrat_rd_data), m_rrat[rrat_rd_idx]);
      end
   end

   task automatic set(input bit v, input int ard, input int rs1, input int rs2, input bit ok, input bit cv);
      ren_valid    = v;
      ren_ard      = AW'(ard);
      ren_rs1      = AW'(rs1);
      ren_rs2      = AW'(rs2);
      rob_alloc_ok = ok;
      commit_valid = cv;
      if (cv && m_rob.size() > 0) begin
         commit_ard     = AW'(m_rob[0].ard);
         commit_prd_new = PW'(m_rob[0].pn);
         commit_prd_old = PW'(m_rob[0].po);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      rrat_rd_idx = rrat_rd_idx + 1'b1;
   endtask

   task automatic run(input bit v, input int ard, input int rs1, input int rs2, input bit ok, input bit cv);
      set(v, ard, rs1, rs2, ok, cv);
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      rrat_rd_idx = '0;
      commit_ard = '0;
      commit_prd_new = '0;
      commit_prd_old = '0;
      set(0, 0, 0, 0, 1, 0);
      tick();
      tick();
      rst = 1'b0;
      set(0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk("lit_reset_count", int'(free_count), 32);
      tick();
      set(1, 5, 5, 0, 1, 0);
      @(negedge clk);
      chk("lit_first_ps1", int'(ren_ps1), 5);
      chk("lit_first_old", int'(rob_prd_old), 5);
      chk("lit_first_new", int'(rob_prd_new), 32);
      chk("lit_first_alloc", int'(rob_alloc_en), 1);
      tick();
      set(0, 0, 5, 0, 1, 0);
      @(negedge clk);
      chk("lit_count_31", int'(free_count), 31);
      chk("lit_rat5_32", int'(ren_ps1), 32);
      tick();
      for (int i = 0; i < 31; i++) run(1, i + 1, i, 31 - i, 1, 0);
      set(1, 7, 7, 0, 1, 0);
      @(negedge clk);
      chk("lit_empty_count", int'(free_count), 0);
      chk("lit_empty_ready", int'(ren_ready), 0);
      chk("lit_empty_alloc", int'(rob_alloc_en), 0);
      tick();
      set(0, 0, 7, 0, 1, 0);
      @(negedge clk);
      chk("lit_stall_rat7", int'(ren_ps1), 39);
      tick();
      set(0, 0, 0, 0, 1, 1);
      @(negedge clk);
      chk("lit_commit_pop", int'(commit_pop), 1);
      tick();
      set(0, 0, 0, 0, 1, 0);
      rrat_rd_idx = 5;
      @(negedge clk);
      chk("lit_commit_count", int'(free_count), 1);
      chk("lit_rrat5", int'(rrat_rd_data), 32);
      tick();
      set(1, 10, 0, 0, 1, 0);
      @(negedge clk);
      chk("lit_recycled_new", int'(rob_prd_new), 5);
      tick();
      for (int i = 0; i < 10; i++) run(0, 0, i, i + 1, 1, 1);
      set(1, 3, 0, 0, 1, 1);
      @(negedge clk);
      chk("lit_count_10", int'(free_count), 10);
      chk("lit_pair_new", int'(rob_prd_new), 1);
      tick();
      set(1, 4, 0, 0, 1, 0);
      @(negedge clk);
      chk("lit_pair_count", int'(free_count), 10);
      chk("lit_pair_next_new", int'(rob_prd_new), 2);
      tick();
      set(1, 6, 0, 0, 0, 0);
      @(negedge clk);
      chk("lit_nok_alloc", int'(rob_alloc_en), 0);
      tick();
      set(0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk("lit_nok_count", int'(free_count), 9);
      tick();
      for (int i = 0; i < 100; i++) run(1, (i * 7) % 32, (i * 3) % 32, (i + 1) % 32, 1, 1);
      for (int i = 0; i < 7; i++) run(1, i + 2, i, i + 9, 1, 0);
      set(1, 3, 0, 0, 1, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("lit_rst_ready", int'(ren_ready), 0);
      chk("lit_rst_pop", int'(commit_pop), 0);
      tick();
      rst = 1'b0;
      set(0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk("lit_rst_count", int'(free_count), 32);
      tick();
      for (int i = 0; i < ARCH; i++) begin
         set(0, 0, i, 31 - i, 1, 0);
         @(negedge clk);
         chk("lit_rat_identity", int'(ren_ps1), i);
         tick();
      end
      set(1, 9, 9, 0, 1, 0);
      @(negedge clk);
      chk("lit_rst_new", int'(rob_prd_new), 32);
      chk("lit_rst_ps1", int'(ren_ps1), 9);
      tick();
`ifdef RENAME_ZERO_REG_EN
      set(1, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk("lit_zr_new", int'(rob_prd_new), 0);
      chk("lit_zr_old", int'(rob_prd_old), 0);
      chk("lit_zr_alloc", int'(rob_alloc_en), 1);
      tick();
      set(0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk("lit_zr_count", int'(free_count), 31);
      tick();
`endif
      run(0, 0, 0, 0, 1, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
